// File: rtl/ir_control.sv
// IR remote frame decoder: times carrier bursts and spaces in ticks and decodes 32-bit
// frames plus repeat codes. Define IR_INVERSE_CHECK_EN to reject frames with bad inverse bytes.
module ir_control #(
   parameter int TICK_DIV        = 500,
   parameter int CNT_W           = 12,
   parameter int LEAD_LOW_MIN    = 800,
   parameter int LEAD_HIGH_MIN   = 350,
   parameter int REPEAT_HIGH_MIN = 180,
   parameter int BIT_LOW_MIN     = 35,
   parameter int BIT_LOW_MAX     = 80,
   parameter int BIT1_MIN        = 112,
   parameter int BIT_HIGH_MAX    = 250,
   parameter int TIMEOUT         = 1200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       irda,
   output logic [7:0] addr,
   output logic [7:0] cmd,
   output logic       data_valid,
   output logic       repeat_o,   // "repeat" is a reserved word
   output logic       err,
   output logic       busy,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEAD_L = 3'd1,
      LEAD_H = 3'd2,
      BIT_L  = 3'd3,
      BIT_H  = 3'd4,
      CHECK  = 3'd5
   } state_t;

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] LLM_C     = CNT_W'(LEAD_LOW_MIN);
   localparam logic [CNT_W-1:0] LHM_C     = CNT_W'(LEAD_HIGH_MIN);
   localparam logic [CNT_W-1:0] RHM_C     = CNT_W'(REPEAT_HIGH_MIN);
   localparam logic [CNT_W-1:0] BLMIN_C   = CNT_W'(BIT_LOW_MIN);
   localparam logic [CNT_W-1:0] BLMAX_C   = CNT_W'(BIT_LOW_MAX);
   localparam logic [CNT_W-1:0] B1MIN_C   = CNT_W'(BIT1_MIN);
   localparam logic [CNT_W-1:0] BHMAX_C   = CNT_W'(BIT_HIGH_MAX);
   localparam logic [CNT_W-1:0] TO_C      = CNT_W'(TIMEOUT);

   state_t             state_q, state_d;
   logic               sync1_q, sync2_q, prev_q;
   logic [PRE_W-1:0]   pre_q, pre_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [5:0]         bit_cnt_q, bit_cnt_d;
   logic [31:0]        sr_q, sr_d;
   logic [7:0]         addr_q, addr_d;
   logic [7:0]         cmd_q, cmd_d;
   logic               seen_q, seen_d;
   logic               dv_q, dv_d;
   logic               rep_q, rep_d;
   logic               err_q, err_d;

   logic fall, rise, edge_det, tick, timeout, accept;

   // Idle-high line: synchronizer and edge history reset to 1 so release never fakes an edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= irda;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign fall     = prev_q & ~sync2_q;
   assign rise     = ~prev_q & sync2_q;
   assign edge_det = fall | rise;

   assign tick  = (pre_q == PRE_LAST);
   assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

   always_comb begin
      cnt_d = cnt_q;
      if (edge_det) begin
         cnt_d = '0;
      end else if (tick && (cnt_q != TO_C)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign timeout = (cnt_q == TO_C);

`ifdef IR_INVERSE_CHECK_EN
   assign accept = (sr_q[15:8] == ~sr_q[7:0]) && (sr_q[31:24] == ~sr_q[23:16]);
`else
   assign accept = 1'b1;
`endif

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      sr_d      = sr_q;
      addr_d    = addr_q;
      cmd_d     = cmd_q;
      seen_d    = seen_q;
      dv_d      = 1'b0;
      rep_d     = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (fall) begin
               state_d = LEAD_L;
            end
         end

         LEAD_L: begin
            if (timeout) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (rise) begin
               // a short burst is treated as line noise, not an error
               state_d = (cnt_q >= LLM_C) ? LEAD_H : IDLE;
            end
         end

         LEAD_H: begin
            if (timeout) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (fall) begin
               if (cnt_q >= LHM_C) begin
                  bit_cnt_d = '0;
                  state_d   = BIT_L;
               end else if (cnt_q >= RHM_C) begin
                  rep_d   = seen_q;
                  state_d = IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end

         BIT_L: begin
            if (timeout) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (rise) begin
               if ((cnt_q >= BLMIN_C) && (cnt_q <= BLMAX_C)) begin
                  state_d = (bit_cnt_q == 6'd32) ? CHECK : BIT_H;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end

         BIT_H: begin
            if (timeout) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (fall) begin
               if ((cnt_q < BLMIN_C) || (cnt_q > BHMAX_C)) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  sr_d      = {(cnt_q >= B1MIN_C), sr_q[31:1]};
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  state_d   = BIT_L;
               end
            end
         end

         CHECK: begin
            if (accept) begin
               addr_d = sr_q[7:0];
               cmd_d  = sr_q[23:16];
               seen_d = 1'b1;
               dv_d   = 1'b1;
            end else begin
               err_d  = 1'b1;
            end
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         pre_q     <= '0;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         sr_q      <= '0;
         addr_q    <= '0;
         cmd_q     <= '0;
         seen_q    <= 1'b0;
         dv_q      <= 1'b0;
         rep_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         sr_q      <= sr_d;
         addr_q    <= addr_d;
         cmd_q     <= cmd_d;
         seen_q    <= seen_d;
         dv_q      <= dv_d;
         rep_q     <= rep_d;
         err_q     <= err_d;
      end
   end

   // Pulses are registered alongside addr/cmd so a data_valid sees the new bytes.
   assign addr       = addr_q;
   assign cmd        = cmd_q;
   assign data_valid = dv_q;
   assign repeat_o   = rep_q;
   assign err        = err_q;
   assign busy       = (state_q != IDLE);
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_ir_control.sv
// Bench for ir_control with scaled timing: random and directed pulse trains are decoded
// by a duration-based reference model and compared event by event.
module tb_ir_control;

  localparam int TO        = 24;
  localparam int LEAD_LMIN = 16;
  localparam int LHM       = 7;
  localparam int RHM       = 3;
  localparam int BLMIN     = 1;
  localparam int BLMAX     = 3;
  localparam int B1        = 4;
  localparam int BHMAX     = 8;

  localparam logic [1:0] EV_DV  = 2'd1;
  localparam logic [1:0] EV_REP = 2'd2;
  localparam logic [1:0] EV_ERR = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       irda = 1'b1;
  logic [7:0] addr, cmd;
  logic       data_valid, repeat_o, err, busy;
  logic [2:0] state_dbg;

  ir_control #(
    .TICK_DIV(1), .CNT_W(12), .LEAD_LOW_MIN(LEAD_LMIN), .LEAD_HIGH_MIN(LHM),
    .REPEAT_HIGH_MIN(RHM), .BIT_LOW_MIN(BLMIN), .BIT_LOW_MAX(BLMAX),
    .BIT1_MIN(B1), .BIT_HIGH_MAX(BHMAX), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .irda(irda), .addr(addr), .cmd(cmd),
    .data_valid(data_valid), .repeat_o(repeat_o), .err(err), .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];
  int          seg_q[$];
  logic        seen_m = 1'b0;
  logic [7:0]  addr_m = 8'h00;
  logic [7:0]  cmd_m  = 8'h00;

  int   excl_viol = 0;
  int   long_viol = 0;
  logic busy_seen = 1'b0;
  int   err_cyc = 0;
  int   last_edge_cyc = 0;
  logic dv_p = 1'b0, rep_p = 1'b0, err_p = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (data_valid) obs_q.push_back({EV_DV, addr, cmd});
      if (repeat_o)   obs_q.push_back({EV_REP, addr, cmd});
      if (err) begin
        obs_q.push_back({EV_ERR, addr, cmd});
        err_cyc = cyc;
      end
      if (int'(data_valid) + int'(repeat_o) + int'(err) > 1) excl_viol++;
      if ((data_valid && dv_p) || (repeat_o && rep_p) || (err && err_p)) long_viol++;
      if (busy) busy_seen = 1'b1;
    end
    dv_p  = data_valid;
    rep_p = repeat_o;
    err_p = err;
  end

  // reference model: walks the burst/space durations (in ticks = clks - 1) by the decode rules
  task automatic push_err();
    exp_q.push_back({EV_ERR, addr_m, cmd_m});
  endtask

  task automatic model_run();
    int i = 0;
    int n = seg_q.size();
    while (i < n) begin
      int c = seg_q[i] - 1;
      if (c >= TO) begin push_err(); i += 2; continue; end
      if (c < LEAD_LMIN) begin i += 2; continue; end
      if (i + 1 >= n) break;
      c = seg_q[i+1] - 1;
      if (c >= TO) begin push_err(); i += 2; continue; end
      if (c < RHM) begin push_err(); i += 4; continue; end
      if (c < LHM) begin
        if (seen_m) exp_q.push_back({EV_REP, addr_m, cmd_m});
        i += 4;
        continue;
      end
      begin
        int j = i + 2;
        int nb = 0;
        logic [31:0] w = '0;
        bit done = 0;
        while (!done) begin
          if (j >= n) begin
            done = 1; i = n;
          end else begin
            c = seg_q[j] - 1;
            if (c >= TO || c < BLMIN || c > BLMAX) begin
              push_err(); i = j + 2; done = 1;
            end else if (nb == 32) begin
              logic ok;
`ifdef IR_INVERSE_CHECK_EN
              ok = (w[15:8] == ~w[7:0]) && (w[31:24] == ~w[23:16]);
`else
              ok = 1'b1;
`endif
              if (ok) begin
                addr_m = w[7:0];
                cmd_m  = w[23:16];
                seen_m = 1'b1;
                exp_q.push_back({EV_DV, addr_m, cmd_m});
              end else begin
                push_err();
              end
              i = j + 2; done = 1;
            end else if (j + 1 >= n) begin
              done = 1; i = n;
            end else begin
              c = seg_q[j+1] - 1;
              if (c >= TO) begin
                push_err(); i = j + 2; done = 1;
              end else if (c < BLMIN || c > BHMAX) begin
                push_err(); i = j + 4; done = 1;
              end else begin
                w[nb] = (c >= B1);
                nb++;
                j += 2;
              end
            end
          end
        end
      end
    end
  endtask

  // driver tasks
  task automatic drive_seg(input logic lvl, input int d);
    if (irda !== lvl) last_edge_cyc = cyc;
    irda = lvl;
    repeat (d) @(posedge clk);
    #1;
  endtask

  task automatic build_frame(input logic [31:0] w, input bit fixed);
    seg_q.push_back(fixed ? 18 : int'($urandom_range(17, 22)));
    seg_q.push_back(fixed ? 9 : int'($urandom_range(8, 12)));
    for (int b = 0; b < 32; b++) begin
      seg_q.push_back(fixed ? 2 : int'($urandom_range(2, 4)));
      if (w[b]) seg_q.push_back(fixed ? 6 : int'($urandom_range(5, 9)));
      else      seg_q.push_back(fixed ? 2 : int'($urandom_range(2, 4)));
    end
    seg_q.push_back(fixed ? 2 : int'($urandom_range(2, 4)));
    seg_q.push_back(40);
  endtask

  task automatic run_item(input string tag);
    model_run();
    @(posedge clk); #1;
    for (int k = 0; k < seg_q.size(); k++) drive_seg(k % 2 == 1, seg_q[k]);
    repeat (5) @(posedge clk);
    #1;
    check({tag, "_nev"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) check(tag, obs_q.pop_front(), exp_q.pop_front());
    check({tag, "_idle"}, busy, 1'b0);
    obs_q.delete();
    exp_q.delete();
    seg_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    irda = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    seen_m = 1'b0;
    addr_m = 8'h00;
    cmd_m  = 8'h00;
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  a, c;
    int          kind, idx, v, lat;

    do_reset();
    check("rst_state", state_dbg, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_pulses", {data_valid, repeat_o, err}, 3'b000);
    check("rst_addr", addr, 8'h00);
    check("rst_cmd", cmd, 8'h00);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // repeat code straight after reset: no pulse
    seg_q = '{18, 4, 2, 40};
    run_item("rep_cold");

    // canonical frame 00 FF 45 BA
    build_frame({8'hBA, 8'h45, 8'hFF, 8'h00}, 1);
    run_item("frame_45");
    check("frame_45_addr", addr, 8'h00);
    check("frame_45_cmd", cmd, 8'h45);

    // repeat after an accepted frame
    seg_q = '{18, 4, 2, 40};
    run_item("rep_warm");
    check("rep_warm_cmd", cmd, 8'h45);

    // short burst: busy rises then drops, no pulses
    busy_seen = 1'b0;
    seg_q = '{8, 40};
    run_item("glitch");
    check("glitch_busy_seen", busy_seen, 1'b1);

    // bad inverse command byte
    build_frame({8'hCB, 8'h34, 8'hED, 8'h12}, 1);
    run_item("frame_34");
    build_frame({8'h00, 8'h45, 8'hFF, 8'h00}, 1);
    run_item("bad_inv");
`ifdef IR_INVERSE_CHECK_EN
    check("bad_inv_cmd", cmd, 8'h34);
`else
    check("bad_inv_cmd", cmd, 8'h45);
`endif

    // line held high after bit 10
    seg_q = '{18, 9};
    for (int b = 0; b < 10; b++) begin
      seg_q.push_back(2);
      seg_q.push_back((b % 3 == 0) ? 6 : 2);
    end
    seg_q.push_back(2);
    seg_q.push_back(30);
    err_cyc = 0;
    run_item("stall");
    lat = err_cyc - last_edge_cyc;
    check("stall_latency_ok", (lat >= TO && lat <= TO + 6), 1'b1);

    // reset during bit 20, then a clean frame
    build_frame({8'h5A, 8'hA5, 8'h3C, 8'hC3}, 1);
    @(posedge clk); #1;
    for (int k = 0; k < 42; k++) drive_seg(k % 2 == 1, seg_q[k]);
    drive_seg(1'b0, 1);
    seg_q.delete();
    do_reset();
    check("midrst_state", state_dbg, 3'd0);
    check("midrst_out", {busy, data_valid, repeat_o, err}, 4'b0000);
    check("midrst_addr", addr, 8'h00);
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("midrst_nev", obs_q.size(), 0);
    obs_q.delete();
    build_frame({8'h87, 8'h78, 8'hD5, 8'h2A}, 1);
    run_item("post_rst");
    check("post_rst_addr", addr, 8'h2A);

    // randomized mix
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 5);
      a = 8'($urandom);
      c = 8'($urandom);
      case (kind)
        0: build_frame({~c, c, ~a, a}, 0);
        1: begin w = $urandom; build_frame(w, 0); end
        2: begin
          seg_q.push_back($urandom_range(17, 22));
          seg_q.push_back($urandom_range(4, 7));
          seg_q.push_back(2);
          seg_q.push_back(40);
        end
        3: begin
          seg_q.push_back($urandom_range(2, 16));
          seg_q.push_back(40);
        end
        4: begin
          build_frame({~c, c, ~a, a}, 0);
          idx = $urandom_range(0, seg_q.size() - 2);
          v = $urandom_range(1, 21);
          seg_q[idx] = (v == 21) ? 30 : v;
        end
        default: begin
          seg_q.push_back($urandom_range(17, 22));
          seg_q.push_back($urandom_range(1, 3));
          seg_q.push_back(2);
          seg_q.push_back(40);
        end
      endcase
      run_item($sformatf("rnd%0d_k%0d", t, kind));
    end

    check("exclusive_pulses", excl_viol, 0);
    check("single_cycle_pulses", long_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
